ibex_ex_fu_dispatch: RTL and testbench

Parametrised dispatcher between the execute stage and NumUnits multi-cycle functional units, for example multiply/divide, FPU and crypto.
- Issues each request to the addressed unit over a valid/ready handshake.
- Tracks outstanding operations in an in-order ID FIFO of depth Depth.
- Returns results strictly in issue order through a registered response stage.
- Supports whole-pipeline flush and optional sticky status accumulation.
- Sits between the ID/EX issue logic and the functional units; replaces the single hard-wired FPU/multdiv select with a generic N-unit in-order scheme.

---
 rtl/ibex_ex_fu_dispatch_if.sv | 53 +++++
 rtl/ibex_ex_fu_dispatch.sv | 158 +++++++++++++++
 tb/tb_ibex_ex_fu_dispatch.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_ex_fu_dispatch_if.sv
// Handshake bundle between the execute-stage issue logic, the functional
// units and the ibex_ex_fu_dispatch block. Signal suffixes (_i/_o) are
// given from the dispatcher's point of view. The dispatcher connects via
// the slave modport; the environment (issue logic, units, consumer)
// connects via the master modport.
interface ibex_ex_fu_dispatch_if #(
    parameter int unsigned NumUnits = 3,
    parameter int unsigned Width    = 32,
    parameter int unsigned NumOps   = 3,
    parameter int unsigned StatusW  = 5
);
    localparam int unsigned UnitIdW = $clog2(NumUnits + 1);

    // Request from the issue logic
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [UnitIdW-1:0]          req_unit_i;
    logic [NumOps*Width-1:0]     req_operands_i;

    // Issue towards the units
    logic [NumUnits-1:0]         fu_valid_o;
    logic [NumUnits-1:0]         fu_ready_i;
    logic [NumOps*Width-1:0]     fu_operands_o;

    // Results coming back from the units
    logic [NumUnits-1:0]         fu_valid_i;
    logic [NumUnits-1:0]         fu_ready_o;
    logic [NumUnits*Width-1:0]   fu_result_i;
    logic [NumUnits*StatusW-1:0] fu_status_i;

    // In-order response to the consumer
    logic                        rsp_valid_o;
    logic                        rsp_ready_i;
    logic [Width-1:0]            rsp_result_o;
    logic [UnitIdW-1:0]          rsp_unit_o;
    logic                        rsp_err_o;

    modport slave (
        input  req_valid_i, req_unit_i, req_operands_i,
        input  fu_ready_i, fu_valid_i, fu_result_i, fu_status_i,
        input  rsp_ready_i,
        output req_ready_o, fu_valid_o, fu_operands_o, fu_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_unit_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_unit_i, req_operands_i,
        output fu_ready_i, fu_valid_i, fu_result_i, fu_status_i,
        output rsp_ready_i,
        input  req_ready_o, fu_valid_o, fu_operands_o, fu_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_unit_o, rsp_err_o
    );
endinterface

// File: rtl/ibex_ex_fu_dispatch.sv
// Generic in-order dispatcher between the execute stage and NumUnits
// multi-cycle functional units. Requests are steered to one unit, their
// unit IDs are remembered in an in-order FIFO, and results are returned
// strictly in issue order through a registered response stage.
// Requests for an unknown unit ID are accepted and answered with an error
// response (result 0) without involving any unit.
// Optional feature: define IBEX_EX_DISPATCH_STATUS_EN to build the sticky
// status_o accumulator; otherwise status_o is tied to zero.
module ibex_ex_fu_dispatch #(
    parameter int unsigned NumUnits = 3,
    parameter int unsigned Width    = 32,
    parameter int unsigned NumOps   = 3,
    parameter int unsigned Depth    = 4,
    parameter int unsigned StatusW  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ibex_ex_fu_dispatch_if.slave         bus,
    output logic                         fu_flush_o,
    input  logic                         flush_i,
    output logic [StatusW-1:0]           status_o,
    input  logic                         status_clr_i,
    output logic [$clog2(Depth+1)-1:0]   outstanding_o,
    output logic                         busy_o
);
    localparam int unsigned UnitIdW = $clog2(NumUnits + 1);
    localparam int unsigned CntW    = $clog2(Depth + 1);
    localparam int unsigned PtrW    = $clog2(Depth);

    typedef struct packed {
        logic               err;
        logic [UnitIdW-1:0] unit;
    } entry_t;

    entry_t                  fifo_q [Depth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic                    rsp_valid_q;
    logic [Width-1:0]        rsp_result_q;
    logic [UnitIdW-1:0]      rsp_unit_q;
    logic                    rsp_err_q;

    logic                    full, empty, can_issue;
    logic                    req_id_ok, req_unit_rdy, push;
    logic                    out_free, pop_ok, head_done, pop;
    entry_t                  head;
    logic [Width-1:0]        head_result;
    logic [StatusW-1:0]      head_status;
    logic [NumOps*Width-1:0] operands;

    assign full      = (count_q == CntW'(Depth));
    assign empty     = (count_q == '0);
    assign can_issue = !full && !flush_i;
    assign head      = fifo_q[rd_ptr_q];
    assign out_free  = !rsp_valid_q || bus.rsp_ready_i;
    assign pop_ok    = !empty && out_free && !flush_i;
    assign pop       = pop_ok && head_done;

    assign operands          = bus.req_operands_i;
    assign bus.fu_operands_o = operands;
    assign fu_flush_o        = flush_i;

    // Issue path: decode the target unit and gate by FIFO space and flush.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        req_id_ok      = 1'b0;
        req_unit_rdy   = 1'b1;
        bus.fu_valid_o = '0;
        for (int u = 0; u < NumUnits; u++) begin
            if (bus.req_unit_i == UnitIdW'(u)) begin
                req_id_ok         = 1'b1;
                req_unit_rdy      = bus.fu_ready_i[u];
                bus.fu_valid_o[u] = bus.req_valid_i && can_issue;
            end
        end
    end

    assign bus.req_ready_o = can_issue && req_unit_rdy;
    assign push            = bus.req_valid_i && bus.req_ready_o;

    // Return path: only the unit owning the oldest entry is offered fu_ready_o.
    always_comb begin
        head_done      = head.err;
        head_result    = '0;
        head_status    = '0;
        bus.fu_ready_o = '0;
        for (int u = 0; u < NumUnits; u++) begin
            if (!head.err && head.unit == UnitIdW'(u)) begin
                head_done         = bus.fu_valid_i[u];
                head_result       = bus.fu_result_i[u*Width +: Width];
                head_status       = bus.fu_status_i[u*StatusW +: StatusW];
                bus.fu_ready_o[u] = pop_ok;
            end
        end
    end

    // In-order ID storage; occupancy and pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        // NOTE: payload storage has no reset; clearing the pointers is enough to empty the FIFO.
        if (push) begin
            fifo_q[wr_ptr_q] <= '{err: !req_id_ok, unit: bus.req_unit_i};
        end
    end

    // Pointers, occupancy and response register; reset and flush drop all work.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst_i || flush_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_unit_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (pop) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= head_result;
                rsp_unit_q   <= head.unit;
                rsp_err_q    <= head.err;
            end else if (bus.rsp_ready_i) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_unit_o   = rsp_unit_q;
    assign bus.rsp_err_o    = rsp_err_q;
    assign outstanding_o    = count_q;
    assign busy_o           = !empty || rsp_valid_q;

`ifdef IBEX_EX_DISPATCH_STATUS_EN
    logic [StatusW-1:0] status_q;

    // Sticky OR of the status of every loaded response; clear wins over accumulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else if (status_clr_i) begin
            status_q <= '0;
        end else if (pop) begin
            status_q <= status_q | head_status;
        end
    end

    assign status_o = status_q;
`else
    logic unused_status;
    assign unused_status = ^{status_clr_i, head_status};
    assign status_o      = '0;
`endif
endmodule

// File: tb/tb_ibex_ex_fu_dispatch.sv
// Self-checking bench for ibex_ex_fu_dispatch. A queue-based reference
// model (list of outstanding ops, one result queue per unit, a single
// response slot and a status word) predicts every output each cycle;
// directed sequences pin the model with literal expectations, followed by
// a randomized phase with random unit completion, back-pressure, flushes
// and occasional resets.
module tb_ibex_ex_fu_dispatch;
    localparam int NU    = 3;
    localparam int W     = 32;
    localparam int NOPS  = 3;
    localparam int DEPTH = 4;
    localparam int SW    = 5;
    localparam int UIDW  = $clog2(NU + 1);
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef IBEX_EX_DISPATCH_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, fu_flush, status_clr, busy;
    logic [SW-1:0] status;
    logic [CW-1:0] outstanding;

    ibex_ex_fu_dispatch_if #(.NumUnits(NU), .Width(W), .NumOps(NOPS), .StatusW(SW)) bus ();

    ibex_ex_fu_dispatch #(
        .NumUnits(NU), .Width(W), .NumOps(NOPS), .Depth(DEPTH), .StatusW(SW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .fu_flush_o    (fu_flush),
        .flush_i       (flush),
        .status_o      (status),
        .status_clr_i  (status_clr),
        .outstanding_o (outstanding),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_checks, n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { int unsigned unit; bit err; } op_t;
    typedef struct { logic [W-1:0] res; logic [SW-1:0] st; } uent_t;
    op_t           exp_q [$];
    uent_t         uq [NU][$];
    bit            m_valid;
    logic [W-1:0]  m_res;
    int unsigned   m_unit;
    bit            m_err;
    logic [SW-1:0] m_status;
    bit            acc [NU];
    bit            rand_mode;

    // Compare the DUT against the model, then advance the model over the next edge.
    task automatic model_step();
        int unsigned   ru;
        bit            id_ok, full, can, e_req_ready, free, pop, push;
        logic [NU-1:0] e_fu_valid, e_fu_ready;
        op_t           hd, tmp;
        uent_t         ue;
        for (int u = 0; u < NU; u++) acc[u] = 1'b0;
        if (rst) begin
            exp_q.delete();
            for (int u = 0; u < NU; u++) uq[u].delete();
            m_valid  = 1'b0;
            m_status = '0;
            return;
        end
        check("rsp_valid", bus.rsp_valid_o, m_valid);
        if (m_valid) begin
            check("rsp_result", bus.rsp_result_o, m_res);
            check("rsp_unit", bus.rsp_unit_o, m_unit);
            check("rsp_err", bus.rsp_err_o, m_err);
        end
        check("outstanding", outstanding, exp_q.size());
        check("busy", busy, (exp_q.size() != 0) || m_valid);
        check("status", status, STATUS_ON ? m_status : '0);

        ru          = bus.req_unit_i;
        id_ok       = ru < NU;
        full        = exp_q.size() == DEPTH;
        can         = !full && !flush;
        e_req_ready = can && (id_ok ? bus.fu_ready_i[ru] : 1'b1);
        e_fu_valid  = '0;
        if (bus.req_valid_i && can && id_ok) e_fu_valid[ru] = 1'b1;
        free        = !m_valid || bus.rsp_ready_i;
        e_fu_ready  = '0;
        pop         = 1'b0;
        if (exp_q.size() > 0 && free && !flush) begin
            hd = exp_q[0];
            if (hd.err) pop = 1'b1;
            else begin
                e_fu_ready[hd.unit] = 1'b1;
                pop = bus.fu_valid_i[hd.unit];
            end
        end
        check("req_ready", bus.req_ready_o, e_req_ready);
        check("fu_valid_o", bus.fu_valid_o, e_fu_valid);
        check("fu_ready_o", bus.fu_ready_o, e_fu_ready);
        check("fu_flush", fu_flush, flush);
        check("fu_operands", bus.fu_operands_o, bus.req_operands_i[63:0]);
        push = bus.req_valid_i && e_req_ready;

        if (flush) begin
            exp_q.delete();
            for (int u = 0; u < NU; u++) uq[u].delete();
            m_valid = 1'b0;
        end else begin
            if (pop) begin
                hd      = exp_q.pop_front();
                m_valid = 1'b1;
                m_unit  = hd.unit;
                m_err   = hd.err;
                if (hd.err) m_res = '0;
                else begin
                    ue       = uq[hd.unit].pop_front();
                    m_res    = ue.res;
                    m_status = m_status | ue.st;
                    acc[hd.unit] = 1'b1;
                end
            end else if (bus.rsp_ready_i) begin
                m_valid = 1'b0;
            end
            if (push) begin
                tmp.unit = ru;
                tmp.err  = !id_ok;
                exp_q.push_back(tmp);
                if (id_ok) begin
                    ue.res = bus.req_operands_i[W-1:0];
                    ue.st  = bus.req_operands_i[W +: SW];
                    uq[ru].push_back(ue);
                end
            end
        end
        if (status_clr) m_status = '0;
    endtask

    always @(negedge clk) model_step();

    // Units present the head of their own queue; random mode also randomizes everything else.
    task automatic drive_units();
        logic [NU*W-1:0]  r;
        logic [NU*SW-1:0] s;
        r = '0;
        s = '0;
        for (int u = 0; u < NU; u++) begin
            if (uq[u].size() > 0) begin
                r[u*W +: W]   = uq[u][0].res;
                s[u*SW +: SW] = uq[u][0].st;
            end
        end
        bus.fu_result_i = r;
        bus.fu_status_i = s;
        if (rand_mode) begin
            for (int u = 0; u < NU; u++)
                bus.fu_valid_i[u] = (uq[u].size() > 0) &&
                                    ((bus.fu_valid_i[u] && !acc[u]) || $urandom_range(0, 2) == 0);
            bus.fu_ready_i     = NU'($urandom);
            bus.req_valid_i    = 1'($urandom_range(0, 1));
            bus.req_unit_i     = ($urandom_range(0, 7) == 0) ? UIDW'(NU) : UIDW'($urandom_range(0, NU - 1));
            bus.req_operands_i = {$urandom, $urandom, $urandom};
            bus.rsp_ready_i    = $urandom_range(0, 3) != 0;
            flush              = $urandom_range(0, 63) == 0;
            status_clr         = !flush && $urandom_range(0, 31) == 0;
            rst                = $urandom_range(0, 499) == 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_units();
    endtask

    task automatic set_req(input int unsigned u, input logic [W-1:0] res, input logic [SW-1:0] st);
        logic [NOPS*W-1:0] ops;
        ops            = '0;
        ops[W-1:0]     = res;
        ops[W +: SW]   = st;
        ops[2*W +: W]  = $urandom;
        bus.req_valid_i    = 1'b1;
        bus.req_unit_i     = UIDW'(u);
        bus.req_operands_i = ops;
    endtask

    task automatic issue(input int unsigned u, input logic [W-1:0] res, input logic [SW-1:0] st);
        set_req(u, res, st);
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        flush      = 1'b0;
        status_clr = 1'b0;
        while ((exp_q.size() > 0 || m_valid) && n < 100) begin
            for (int u = 0; u < NU; u++) bus.fu_valid_i[u] = uq[u].size() > 0;
            tick();
            n++;
        end
        bus.fu_valid_i = '0;
        check("drain_in_time", n < 100, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rand_mode = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        status_clr = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_unit_i = '0;
        bus.req_operands_i = '0;
        bus.fu_ready_i = '1;
        bus.fu_valid_i = '0;
        bus.fu_result_i = '0;
        bus.fu_status_i = '0;
        bus.rsp_ready_i = 1'b0;

        // Reset for two cycles
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid_o, 0);
        check("reset_outstanding", outstanding, 0);
        check("reset_busy", busy, 0);
        check("reset_status", status, 0);

        // Out-of-order completion: unit 0 finishes first, responses stay in issue order
        bus.rsp_ready_i = 1'b1;
        issue(2, 32'hB, '0);
        issue(0, 32'hA, '0);
        bus.fu_valid_i = 3'b001;
        tick();
        tick();
        bus.fu_valid_i = 3'b101;
        tick();
        bus.fu_valid_i = 3'b001;
        @(negedge clk);
        check("ooo_first_valid", bus.rsp_valid_o, 1);
        check("ooo_first_result", bus.rsp_result_o, 32'hB);
        check("ooo_first_unit", bus.rsp_unit_o, 2);
        tick();
        bus.fu_valid_i = 3'b000;
        @(negedge clk);
        check("ooo_second_result", bus.rsp_result_o, 32'hA);
        check("ooo_second_unit", bus.rsp_unit_o, 0);
        drain();

        // Full FIFO with a stalled consumer
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) issue(1, 32'h10 + i, '0);
        set_req(1, 32'h20, '0);
        bus.fu_valid_i = 3'b010;
        @(negedge clk);
        check("full_outstanding", outstanding, 4);
        check("full_req_ready", bus.req_ready_o, 0);
        check("full_fu_ready", bus.fu_ready_o, 3'b010);
        tick();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check("full_pop_outstanding", outstanding, 3);
        check("full_pop_result", bus.rsp_result_o, 32'h10);
        check("full_req_ready_after_pop", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("push_pop_outstanding", outstanding, 3);
        check("push_pop_result", bus.rsp_result_o, 32'h11);
        drain();

        // Invalid unit ID
        bus.rsp_ready_i = 1'b0;
        set_req(3, 32'h55, '0);
        @(negedge clk);
        check("inv_fu_valid", bus.fu_valid_o, 0);
        check("inv_req_ready", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("inv_n1_valid", bus.rsp_valid_o, 0);
        tick();
        @(negedge clk);
        check("inv_n2_valid", bus.rsp_valid_o, 1);
        check("inv_n2_err", bus.rsp_err_o, 1);
        check("inv_n2_result", bus.rsp_result_o, 0);
        drain();

        // Flush with three outstanding ops and a pending request
        bus.rsp_ready_i = 1'b0;
        issue(0, 32'h1, '0);
        issue(1, 32'h2, '0);
        issue(2, 32'h3, '0);
        set_req(0, 32'h77, '0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_fu_flush", fu_flush, 1);
        check("flush_req_ready", bus.req_ready_o, 0);
        check("flush_outstanding_before", outstanding, 3);
        tick();
        flush = 1'b0;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("flush_outstanding_after", outstanding, 0);
        check("flush_rsp_valid_after", bus.rsp_valid_o, 0);

`ifdef IBEX_EX_DISPATCH_STATUS_EN
        // Sticky status accumulation and clear priority
        issue(0, 32'h1, 5'h01);
        issue(0, 32'h2, 5'h04);
        drain();
        @(negedge clk);
        check("status_accum", status, 5'h05);
        issue(1, 32'h3, 5'h02);
        bus.fu_valid_i = 3'b010;
        bus.rsp_ready_i = 1'b1;
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        bus.fu_valid_i = 3'b000;
        @(negedge clk);
        check("status_clr_load_valid", bus.rsp_valid_o, 1);
        check("status_clr_priority", status, 5'h00);
        drain();
`endif

        // Randomized phase
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
